// File: rtl/pong_input_if.sv
// Button/vsync input bundle and the decoded per-frame controls for the pong input block.
interface pong_input_if;
    logic [5:0] btn_in;
    logic       vsync;
    logic       frame_tick;
    logic [5:0] btn_level;
    logic [1:0] p1_delta;
    logic [1:0] p2_delta;
    logic       p1_srv;
    logic       p2_srv;

    modport master (
        output btn_in, vsync,
        input  frame_tick, btn_level, p1_delta, p2_delta, p1_srv, p2_srv
    );

    modport slave (
        input  btn_in, vsync,
        output frame_tick, btn_level, p1_delta, p2_delta, p1_srv, p2_srv
    );
endinterface

// File: rtl/pong_input.sv
// Pong controls: synchronise and debounce six buttons, then sample paddle
// direction and sticky serve requests once per frame on the vsync falling edge.
module pong_input #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_BITS     = 16
) (
    input  logic         clk,
    input  logic         rst,
    pong_input_if.slave  bus
);
    localparam int unsigned NBTN   = 6;
    localparam int unsigned P1_UP  = 0;
    localparam int unsigned P1_DN  = 1;
    localparam int unsigned P1_SRV = 2;
    localparam int unsigned P2_UP  = 3;
    localparam int unsigned P2_DN  = 4;
    localparam int unsigned P2_SRV = 5;

    // The edge on which the counter would reach all-ones toggles the level instead.
    localparam logic [DB_BITS-1:0] DB_LAST = {{(DB_BITS-1){1'b1}}, 1'b0};

    logic [NBTN-1:0]    sync_q [SYNC_STAGES];
    logic [NBTN-1:0]    sync_c;
    logic [DB_BITS-1:0] cnt_q  [NBTN];
    logic [DB_BITS-1:0] cnt_d  [NBTN];
    logic [NBTN-1:0]    level_q, level_d;
    logic [NBTN-1:0]    rise_c;
    logic               vs_q;
    logic               tick_c;
    logic               tick_q;
    logic               p1_flag_q, p1_flag_d;
    logic               p2_flag_q, p2_flag_d;
    logic               p1_srv_q, p1_srv_d;
    logic               p2_srv_q, p2_srv_d;
    logic [1:0]         p1_delta_q, p1_delta_d;
    logic [1:0]         p2_delta_q, p2_delta_d;

    function automatic logic [1:0] dir(input logic up, input logic dn);
        case ({up, dn})
            2'b10:   dir = 2'b01;
            2'b01:   dir = 2'b11;
            default: dir = 2'b00;
        endcase
    endfunction

    assign sync_c = sync_q[SYNC_STAGES-1];
    assign tick_c = vs_q & ~bus.vsync;

    // Debounce: count consecutive disagreeing cycles, adopt the new value at threshold.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_c[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                level_d[i] = sync_c[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_BITS'(1);
            end
        end
    end

    assign rise_c = level_d & ~level_q;

    // A serve edge on the tick edge itself lands in the flag for the next frame.
    always_comb begin
        p1_flag_d  = (p1_flag_q & ~tick_c) | rise_c[P1_SRV];
        p2_flag_d  = (p2_flag_q & ~tick_c) | rise_c[P2_SRV];
        p1_srv_d   = tick_c & p1_flag_q;
        p2_srv_d   = tick_c & p2_flag_q;
        p1_delta_d = p1_delta_q;
        p2_delta_d = p2_delta_q;
        if (tick_c) begin
            p1_delta_d = dir(level_d[P1_UP], level_d[P1_DN]);
            p2_delta_d = dir(level_d[P2_UP], level_d[P2_DN]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
            level_q    <= '0;
            vs_q       <= 1'b1;
            tick_q     <= 1'b0;
            p1_flag_q  <= 1'b0;
            p2_flag_q  <= 1'b0;
            p1_srv_q   <= 1'b0;
            p2_srv_q   <= 1'b0;
            p1_delta_q <= 2'b00;
            p2_delta_q <= 2'b00;
        end else begin
            sync_q[0] <= bus.btn_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
            level_q    <= level_d;
            vs_q       <= bus.vsync;
            tick_q     <= tick_c;
            p1_flag_q  <= p1_flag_d;
            p2_flag_q  <= p2_flag_d;
            p1_srv_q   <= p1_srv_d;
            p2_srv_q   <= p2_srv_d;
            p1_delta_q <= p1_delta_d;
            p2_delta_q <= p2_delta_d;
        end
    end

    assign bus.frame_tick = tick_q;
    assign bus.btn_level  = level_q;
    assign bus.p1_delta   = p1_delta_q;
    assign bus.p2_delta   = p2_delta_q;
    assign bus.p1_srv     = p1_srv_q;
    assign bus.p2_srv     = p2_srv_q;
endmodule
